// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered one-hot grant.
// Grants are held until done or a TIMEOUT-cycle forced release.
module rr_arbiter8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [2:0]  ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]  gnt_n;
  logic [2:0]  id_n;
  logic        valid_n;
  logic        to_n;

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  off;
  logic [2:0]  sel;

  // rotate so ptr lands at bit 0; lowest set bit is the winner
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    sel = ptr + off;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    id_n    = gnt_id;
    valid_n = gnt_valid;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (En && |req) begin
          gnt_n   = 8'b1 << sel;
          id_n    = sel;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (done || cnt == LAST) begin
          gnt_n   = 8'h00;
          valid_n = 1'b0;
          state_n = IDLE;
          ptr_n   = gnt_id + 3'd1;
          to_n    = ~done;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      timeout   <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors feed an expectation queue;
// a negedge monitor pops and compares against the arbiter outputs.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  rr_arbiter8 #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .En(En),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] id,
                              input logic v,
                              input logic to);
    exp_t e;
    e.gnt   = v ? (8'b1 << id) : 8'h00;
    e.id    = id;
    e.valid = v;
    e.to    = to;
    return e;
  endfunction

  task automatic step(input logic e, input logic [7:0] r,
                      input logic d, input logic [2:0] id,
                      input logic v, input logic to);
    En   = e;
    req  = r;
    done = d;
    @(posedge clk);
    exp_q.push_back(mk(id, v, to));
    #1;
  endtask

  // reset raised mid-cycle: the pending expectation becomes all-zero
  task automatic do_reset();
    rst = 1'b1;
    if (exp_q.size() > 0) exp_q[$] = mk(3'd0, 1'b0, 1'b0);
    @(posedge clk);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0));
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{gnt: gnt, id: gnt_id, valid: gnt_valid, to: timeout};
      nvec++;
      if (a !== e) begin
        nerr++;
        $display("FAIL vec%0d got gnt=%h id=%0d v=%b to=%b want gnt=%h id=%0d v=%b to=%b",
                 nvec, a.gnt, a.id, a.valid, a.to,
                 e.gnt, e.id, e.valid, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    En   = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    @(posedge clk);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0));
    @(posedge clk);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0));
    #1;
    rst = 1'b0;

    // single request, then ptr should be 6
    step(1, 8'h20, 0, 3'd5, 1, 0);
    step(0, 8'h00, 1, 3'd5, 0, 0);
    step(1, 8'hFF, 0, 3'd6, 1, 0);
    step(0, 8'h00, 1, 3'd6, 0, 0);
    // wrap: ptr=7 scans 7,0
    step(1, 8'h41, 0, 3'd0, 1, 0);
    step(0, 8'h00, 1, 3'd0, 0, 0);
    step(1, 8'h03, 0, 3'd1, 1, 0);
    step(0, 8'h00, 1, 3'd1, 0, 0);

    // full-load rotation from ptr=0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 8'hFF, 0, 3'(i), 1, 0);
      step(1, 8'hFF, 1, 3'(i), 0, 0);
    end

    // forced release after 16 cycles (ptr=1, only req0)
    step(1, 8'h01, 0, 3'd0, 1, 0);
    for (int k = 1; k < 16; k++) step(1, 8'h01, 0, 3'd0, 1, 0);
    step(1, 8'h01, 0, 3'd0, 0, 1);
    step(0, 8'h00, 0, 3'd0, 0, 0);

    // done on the expiry cycle: normal release
    step(1, 8'h01, 0, 3'd0, 1, 0);
    for (int k = 1; k < 16; k++) step(1, 8'h01, 0, 3'd0, 1, 0);
    step(0, 8'h00, 1, 3'd0, 0, 0);
    step(0, 8'h00, 0, 3'd0, 0, 0);

    // enable gating and frozen grant
    do_reset();
    step(0, 8'hFF, 0, 3'd0, 0, 0);
    step(0, 8'hFF, 0, 3'd0, 0, 0);
    step(1, 8'hFF, 0, 3'd0, 1, 0);
    step(0, 8'h00, 0, 3'd0, 1, 0);
    step(0, 8'h00, 0, 3'd0, 1, 0);
    step(0, 8'h00, 0, 3'd0, 1, 0);
    step(0, 8'h00, 1, 3'd0, 0, 0);
    step(0, 8'h00, 1, 3'd0, 0, 0);

    // reset while owner 3 holds the grant
    step(1, 8'h08, 0, 3'd3, 1, 0);
    step(0, 8'h00, 0, 3'd3, 1, 0);
    do_reset();
    step(1, 8'h18, 0, 3'd3, 1, 0);
    step(0, 8'h00, 1, 3'd3, 0, 0);
    step(1, 8'h18, 0, 3'd4, 1, 0);
    step(0, 8'h00, 1, 3'd4, 0, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
